// File: rtl/alu_execute_stage_if.sv
// alu_execute_stage_if: start/operand request and result/flag bundle.
// master drives start/opcode/operands; slave (the stage) drives outputs.
interface alu_execute_stage_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  input_start;
  logic [2:0]            input_opcode;
  logic [DATA_WIDTH-1:0] input_operand_A;
  logic [DATA_WIDTH-1:0] input_operand_B;
  logic                  output_busy;
  logic                  output_done;
  logic [DATA_WIDTH-1:0] output_result;
  logic                  output_zero;
  logic                  output_carry;
  logic                  output_overflow;

  modport master (
    output input_start,
    output input_opcode,
    output input_operand_A,
    output input_operand_B,
    input  output_busy,
    input  output_done,
    input  output_result,
    input  output_zero,
    input  output_carry,
    input  output_overflow
  );

  modport slave (
    input  input_start,
    input  input_opcode,
    input  input_operand_A,
    input  input_operand_B,
    output output_busy,
    output output_done,
    output output_result,
    output output_zero,
    output output_carry,
    output output_overflow
  );
endinterface

// File: rtl/alu_execute_stage.sv
// alu_execute_stage: latches operands on start, runs one ALU op, pulses done.
// Ports: CLK, RST_N, bus (slave). EXEC_MUL_EN enables 16-step shift-add MUL.
module alu_execute_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int MUL_ITER   = 16
) (
  input logic                CLK,
  input logic                RST_N,
  alu_execute_stage_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
`ifdef EXEC_MUL_EN
  localparam logic [2:0] OP_MUL = 3'd7;
`endif

  if (MUL_ITER != DATA_WIDTH) begin : g_cfg_check
    $error("MUL_ITER must equal DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
`ifdef EXEC_MUL_EN
    S_MUL  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] result_q, result_d;
  logic         zero_q, zero_d;
  logic         carry_q, carry_d;
  logic         ovf_q, ovf_d;

`ifdef EXEC_MUL_EN
  localparam int CW = $clog2(MUL_ITER);
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] pp;
  logic [2*W-1:0] acc_nx;

  always_comb begin
    pp = '0;
    if (b_q[cnt_q]) begin
      pp = {{W{1'b0}}, a_q} << cnt_q;
    end
    acc_nx = acc_q + pp;
  end
`endif

  logic [W-1:0] alu_res;
  logic         alu_c;
  logic         alu_v;
  logic [W:0]   sum;
  logic [W:0]   dif;

  // dif[W] is the unsigned borrow (A < B)
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    dif     = {1'b0, a_q} - {1'b0, b_q};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (a_q[W-1] == b_q[W-1]) &&
                  (sum[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        alu_res = dif[W-1:0];
        alu_c   = dif[W];
        alu_v   = (a_q[W-1] != b_q[W-1]) &&
                  (dif[W-1] != a_q[W-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SLL: alu_res = a_q << b_q[SW-1:0];
      OP_SRL: alu_res = a_q >> b_q[SW-1:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
`ifdef EXEC_MUL_EN
    cnt_d    = cnt_q;
    acc_d    = acc_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.input_start) begin
          op_d    = bus.input_opcode;
          a_d     = bus.input_operand_A;
          b_d     = bus.input_operand_B;
          state_d = S_EXEC;
`ifdef EXEC_MUL_EN
          cnt_d   = '0;
          acc_d   = '0;
          if (bus.input_opcode == OP_MUL) begin
            state_d = S_MUL;
          end
`endif
        end
      end
      S_EXEC: begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        carry_d  = alu_c;
        ovf_d    = alu_v;
        state_d  = S_DONE;
      end
`ifdef EXEC_MUL_EN
      S_MUL: begin
        acc_d = acc_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MUL_ITER - 1)) begin
          result_d = acc_nx[W-1:0];
          zero_d   = (acc_nx[W-1:0] == '0);
          carry_d  = |acc_nx[2*W-1:W];
          ovf_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef EXEC_MUL_EN
      cnt_q    <= '0;
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
`ifdef EXEC_MUL_EN
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
`endif
    end
  end

  assign bus.output_busy     = (state_q != S_IDLE);
  assign bus.output_done     = (state_q == S_DONE);
  assign bus.output_result   = result_q;
  assign bus.output_zero     = zero_q;
  assign bus.output_carry    = carry_q;
  assign bus.output_overflow = ovf_q;
endmodule

// File: tb/tb_alu_execute_stage.sv
// tb_alu_execute_stage: random + directed ops, scoreboard queue and
// a done-driven monitor comparing against an arithmetic reference model.
module tb_alu_execute_stage;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  alu_execute_stage_if bus();

  alu_execute_stage dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        v;
    int          lat;
    int          due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t",
               name, act, req, $time);
    end
  endfunction

  // Reference: plain integer arithmetic on the opcode's definition
  function automatic exp_t model(logic [2:0] op, logic [15:0] a,
                                 logic [15:0] b);
    exp_t e;
    int unsigned ua = a;
    int unsigned ub = b;
    int sa = $signed(a);
    int sb_ = $signed(b);
    int unsigned p;
    int s;
    e.res = 16'h0;
    e.c = 1'b0;
    e.v = 1'b0;
    e.lat = 1;
    e.due = 0;
    case (op)
      3'd0: begin
        p = ua + ub;
        e.res = 16'(p);
        e.c = (p > 65535);
        s = sa + sb_;
        e.v = (s > 32767) || (s < -32768);
      end
      3'd1: begin
        e.res = 16'(ua - ub);
        e.c = (ua < ub);
        s = sa - sb_;
        e.v = (s > 32767) || (s < -32768);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = 16'((ua << (ub % 16)) % 65536);
      3'd6: e.res = 16'(ua >> (ub % 16));
      default: begin
`ifdef EXEC_MUL_EN
        p = ua * ub;
        e.res = 16'(p % 65536);
        e.c = ((p / 65536) != 0);
        e.lat = 16;
`else
        e.res = 16'h0;
`endif
      end
    endcase
    e.z = (e.res == 16'h0);
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse
  initial begin : monitor
    int run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        run = 0;
        continue;
      end
      run = bus.output_busy ? run + 1 : 0;
      if (bus.output_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", bus.output_result, e.res);
          chk("zero", bus.output_zero, e.z);
          chk("carry", bus.output_carry, e.c);
          chk("overflow", bus.output_overflow, e.v);
          chk("done_cycle", cyc, e.due);
          chk("busy_len", run, e.lat + 1);
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (bus.output_busy && k < 200) begin
      @(negedge CLK);
      k++;
    end
    if (bus.output_busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Returns at the negedge after the start edge with start still low
  task automatic issue(logic [2:0] op, logic [15:0] a, logic [15:0] b);
    exp_t e;
    wait_idle();
    bus.input_start = 1'b1;
    bus.input_opcode = op;
    bus.input_operand_A = a;
    bus.input_operand_B = b;
    e = model(op, a, b);
    e.due = cyc + 1 + e.lat;
    sb.push_back(e);
    @(negedge CLK);
    bus.input_start = 1'b0;
    bus.input_opcode = 3'($urandom);
    bus.input_operand_A = 16'($urandom);
    bus.input_operand_B = 16'($urandom);
  endtask

  // Hold a conflicting ADD request through EXEC/MUL and DONE
  task automatic issue_noise(logic [2:0] op, logic [15:0] a,
                             logic [15:0] b);
    exp_t e;
    e = model(op, a, b);
    issue(op, a, b);
    bus.input_start = 1'b1;
    bus.input_opcode = 3'd0;
    repeat (e.lat + 1) begin
      bus.input_operand_A = 16'($urandom);
      bus.input_operand_B = 16'($urandom);
      @(negedge CLK);
    end
    bus.input_start = 1'b0;
    @(negedge CLK);
    chk("no_restart_busy", bus.output_busy, 1'b0);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_busy"}, bus.output_busy, 1'b0);
    chk({tag, "_done"}, bus.output_done, 1'b0);
    chk({tag, "_result"}, bus.output_result, 16'h0);
    chk({tag, "_zero"}, bus.output_zero, 1'b0);
    chk({tag, "_carry"}, bus.output_carry, 1'b0);
    chk({tag, "_ovf"}, bus.output_overflow, 1'b0);
  endtask

  task automatic reset_mid_op();
    issue(3'd7, 16'h0100, 16'h0101);
`ifdef EXEC_MUL_EN
    repeat (7) @(negedge CLK);
`endif
    #2;
    RST_N = 1'b0;
    sb.delete();
    #1;
    check_all_zero("rst_mid");
    repeat (2) @(negedge CLK);
    chk("rst_hold_busy", bus.output_busy, 1'b0);
    #2;
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0: v = 16'h0000;
      1: v = 16'hFFFF;
      2: v = 16'h7FFF;
      3: v = 16'h8000;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  initial begin : stim
    int k;
    bus.input_start = 1'b0;
    bus.input_opcode = 3'd0;
    bus.input_operand_A = 16'h0;
    bus.input_operand_B = 16'h0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    issue(3'd0, 16'h7FFF, 16'h0001);
    issue(3'd1, 16'h0000, 16'h0001);
    issue(3'd1, 16'h1234, 16'h1234);
    issue(3'd7, 16'h0100, 16'h0101);
    issue(3'd5, 16'h0001, 16'h0013);
    issue(3'd6, 16'h8000, 16'h000F);
    issue(3'd0, 16'hFFFF, 16'h0001);
    issue(3'd1, 16'h8000, 16'h0001);
    issue(3'd2, 16'hF0F0, 16'h3C3C);
    issue(3'd3, 16'hF0F0, 16'h0F0F);
    issue(3'd4, 16'hAAAA, 16'hAAAA);
    issue(3'd7, 16'hFFFF, 16'hFFFF);

    issue_noise(3'd7, 16'h0100, 16'h0101);
    issue_noise(3'd0, 16'h1000, 16'h0234);

    issue(3'd0, 16'h1111, 16'h2222);
    reset_mid_op();
    issue(3'd0, 16'h0002, 16'h0003);

    for (int i = 0; i < 60; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end

    k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(negedge CLK);
      k++;
    end
    chk("drain", sb.size(), 0);
    repeat (4) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_execute_stage.md
Name: alu_execute_stage

Overview:
- Execute stage directly downstream of the register file in the 16-bit multi-cycle processor.
- Latches the two register-file read operands on a start request and performs one ALU operation.
- Single-cycle ops use one execute cycle; MUL uses an iterative 16-cycle shift-add.
- Presents a registered result and flags with a one-cycle done pulse to the writeback path.

Parameters:
- DATA_WIDTH, 16, operand/result width; design is verified only at 16.
- MUL_ITER, 16, shift-add iterations for MUL; must equal DATA_WIDTH.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- input_start  input  1  request; sampled only in IDLE.
- input_opcode  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL.
- input_operand_A  input  16  operand A, from register-file output A.
- input_operand_B  input  16  operand B, from register-file output B.
- output_busy  output  1  high in EXEC, MUL and DONE.
- output_done  output  1  one-cycle pulse; result and flags valid while high.
- output_result  output  16  registered result; held until the next done.
- output_zero  output  1  result == 0x0000.
- output_carry  output  1  ADD carry-out, SUB borrow (A<B unsigned), MUL product[31:16] != 0; else 0.
- output_overflow  output  1  signed overflow for ADD/SUB; else 0.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE, every output 0, operand latches 0, iteration counter 0, accumulator 0. Takes effect mid-operation; any in-flight op is discarded and no done pulse is produced.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - input_start=1 at edge N latches A, B and opcode.
  - Next state is MUL if opcode==7, otherwise EXEC.
  - input_start=0 keeps the block in IDLE.
- EXEC: at edge N+1, result and flags are registered and the state moves to DONE; output_done is high during cycle N+1..N+2.
- MUL:
  - 32-bit accumulator, counter 0..15.
  - Each edge adds (A << i) when B[i]==1.
  - After the 16th MUL edge (edge N+16), result = product[15:0] and carry = |product[31:16]; state moves to DONE.
  - MUL latency from the start edge is 16 edges.
- DONE: output_done=1 for exactly one cycle, then IDLE at the next edge. input_start is ignored in DONE; a new start is accepted the cycle after done.
- input_start during EXEC, MUL or DONE is ignored: no queuing, latched operands unchanged.
- Operands are sampled only at the start edge; later changes on input_operand_A/B do not affect the in-flight op.
- Arithmetic:
  - ADD/SUB are modulo 2^16.
  - SLL/SRL shift A logically by B[3:0]; B[15:4] is ignored.
  - AND/OR/XOR are bitwise.
- output_result and the flags hold their value between done pulses; they change only on the DONE-entry edge or on reset.

Optional Feature:
- Macro: EXEC_MUL_EN.
- Defined: MUL is implemented as above.
- Undefined:
  - No MUL state or accumulator is synthesized.
  - Opcode 7 takes the EXEC path with result 0x0000, zero=1, carry=0, overflow=0, done at edge N+1 like other ops.

Test Plan:
- ADD A=0x7FFF B=0x0001, start at edge N -> done high in the cycle after edge N+1; result 0x8000, overflow=1, carry=0, zero=0.
- SUB A=0x0000 B=0x0001 -> result 0xFFFF, carry=1, overflow=0. Then SUB A=0x1234 B=0x1234 -> result 0x0000, zero=1.
- MUL A=0x0100 B=0x0101 (EXEC_MUL_EN defined) -> busy for 17 cycles, done after edge N+16, result 0x0100, carry=1. Same test without the macro -> result 0x0000, zero=1, done after edge N+1.
- SLL A=0x0001 B=0x0013 -> result 0x0008. SRL A=0x8000 B=0x000F -> result 0x0001.
- Start an ADD while a MUL is busy, changing operands mid-MUL -> ignored; the MUL result is unaffected and exactly one done pulse occurs.
- Assert RST_N low at MUL iteration 8 -> all outputs 0 immediately, no done pulse. After release, a new ADD 0x0002+0x0003 -> 0x0005.
